// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves conditional branches, jal/jalr, lui/auipc in one
// cycle, flags front-end mispredicts and queues BTB training updates in a FIFO.
// Optional feature: define BRU_PERF_CNT_EN to add branch/mispredict counters.
module branch_resolve_unit #(
    parameter int ROB_W    = 6,
    parameter int DEST_W   = 6,
    parameter int UQ_DEPTH = 4
) (
    input  logic              cpu_clock_i,
    input  logic              cpu_reset_n_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       operand_1,
    input  logic [31:0]       operand_2,
    input  logic [31:0]       offset,
    input  logic [29:0]       pc,
    input  logic              auipc,
    input  logic              lui,
    input  logic              jal,
    input  logic              jalr,
    input  logic [2:0]        bnch_cond,
    input  logic [ROB_W-1:0]  rob_id_i,
    input  logic [DEST_W-1:0] dest_i,
    input  logic [1:0]        bm_pred_i,
    input  logic [1:0]        btype_i,
    input  logic              btb_vld_i,
    input  logic [29:0]       btb_target_i,
    input  logic              btb_way_i,
    output logic [31:0]       result_o,
    output logic              wb_valid_o,
    output logic [DEST_W-1:0] wb_dest_o,
    output logic              res_valid_o,
    output logic [ROB_W-1:0]  rob_o,
    output logic              excp_o,
    output logic [31:0]       excp_target_o,
    output logic              upd_valid_o,
    input  logic              upd_ready_i,
    output logic [29:0]       upd_pc_o,
    output logic [31:0]       upd_target_o,
    output logic              upd_taken_o,
    output logic [1:0]        upd_type_o,
    output logic              upd_way_o,
    output logic [1:0]        upd_bm_o,
    output logic              upd_mispred_o
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bnch_o,
    output logic [31:0]       perf_misp_o
`endif
);

    localparam int IDX_W = $clog2(UQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [1:0] TYPE_BRANCH = 2'b00;
    localparam logic [1:0] TYPE_JUMP   = 2'b10;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  btype;
        logic        way;
        logic [1:0]  bm;
        logic        mispred;
    } upd_entry_t;

    // ------------------------------------------------------------------
    // Decode and resolution
    // ------------------------------------------------------------------
    logic        is_jump;
    logic        is_branch;
    logic        is_cf;
    logic        cond_true;
    logic        taken;
    logic [31:0] pc_byte;
    logic [31:0] seq_pc;
    logic [31:0] rel_target;
    logic [31:0] jalr_target;
    logic [31:0] next_pc;
    logic [1:0]  op_type;
    logic        mispred;
    logic [31:0] result_d;
    logic        wb_en;

    assign is_jump     = jal | jalr;
    assign is_branch   = !(lui | auipc | jal | jalr);
    assign is_cf       = is_jump | is_branch;
    assign pc_byte     = {pc, 2'b00};
    assign seq_pc      = pc_byte + 32'd4;
    assign rel_target  = pc_byte + offset;
    assign jalr_target = (operand_1 + offset) & ~32'd1;

    // Evaluate the branch condition selected by funct3.
    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        cond_true = 1'b0;
        case (bnch_cond)
            3'b000:  cond_true = (operand_1 == operand_2);
            3'b001:  cond_true = (operand_1 != operand_2);
            3'b100:  cond_true = ($signed(operand_1) <  $signed(operand_2));
            3'b101:  cond_true = ($signed(operand_1) >= $signed(operand_2));
            3'b110:  cond_true = (operand_1 <  operand_2);
            3'b111:  cond_true = (operand_1 >= operand_2);
            default: cond_true = 1'b0;
        endcase
    end

    assign taken   = is_jump | (is_branch & cond_true);
    assign next_pc = jalr ? jalr_target : (taken ? rel_target : seq_pc);
    assign op_type = is_jump ? TYPE_JUMP : TYPE_BRANCH;

    assign mispred = is_cf & (!btb_vld_i
                             | ({btb_target_i, 2'b00} != next_pc)
                             | (btype_i != op_type)
                             | (is_branch & (cond_true != bm_pred_i[1])));

    assign result_d = lui ? offset : (auipc ? rel_target : seq_pc);
    assign wb_en    = (lui | auipc | jal | jalr) & (dest_i != '0);

    // ------------------------------------------------------------------
    // BTB update queue
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    upd_entry_t       uq_mem [UQ_DEPTH];
    upd_entry_t       head;
    upd_entry_t       enq_entry;
    logic             uq_full;
    logic             uq_empty;
    logic             accept;
    logic             do_op;
    logic             enq;
    logic             deq;

    assign uq_empty = (wr_ptr_q == rd_ptr_q);
    assign uq_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    assign ready_o = !uq_full;
    assign accept  = valid_i & ready_o;
    assign do_op   = accept & !flush_i;
    assign enq     = do_op & is_cf;
    assign deq     = upd_valid_o & upd_ready_i;

    assign enq_entry = '{pc: pc, target: next_pc, taken: taken, btype: op_type,
                         way: btb_way_i, bm: bm_pred_i, mispred: mispred};

    // Queue storage; contents are qualified by the pointers.
    // NOTE: storage is not reset -- only the pointers decide which entries are live.
    always_ff @(posedge cpu_clock_i) begin
        if (enq) begin
            uq_mem[wr_ptr_q[IDX_W-1:0]] <= enq_entry;
        end
    end

    // Queue pointers; the extra MSB separates full from empty.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!cpu_reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign head          = uq_mem[rd_ptr_q[IDX_W-1:0]];
    assign upd_valid_o   = !uq_empty;
    assign upd_pc_o      = head.pc;
    assign upd_target_o  = head.target;
    assign upd_taken_o   = head.taken;
    assign upd_type_o    = head.btype;
    assign upd_way_o     = head.way;
    assign upd_bm_o      = head.bm;
    assign upd_mispred_o = head.mispred;

    // ------------------------------------------------------------------
    // Registered result / redirect outputs
    // ------------------------------------------------------------------
    // Pulses drop each cycle; data fields only change on an accepted op.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            res_valid_o   <= 1'b0;
            wb_valid_o    <= 1'b0;
            excp_o        <= 1'b0;
            result_o      <= '0;
            rob_o         <= '0;
            wb_dest_o     <= '0;
            excp_target_o <= '0;
        end else begin
            res_valid_o <= do_op;
            wb_valid_o  <= do_op & wb_en;
            excp_o      <= do_op & mispred;
            if (do_op) begin
                result_o      <= result_d;
                rob_o         <= rob_id_i;
                wb_dest_o     <= dest_i;
                excp_target_o <= next_pc;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Resolved control-flow and mispredict counters, wrapping at 2^32.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            perf_bnch_o <= '0;
            perf_misp_o <= '0;
        end else begin
            if (enq)           perf_bnch_o <= perf_bnch_o + 32'd1;
            if (enq & mispred) perf_misp_o <= perf_misp_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scenarios plus randomized traffic checked
// against a behavioural model of resolution rules and a queue of BTB updates.
module tb_branch_resolve_unit;

    localparam int ROB_W    = 6;
    localparam int DEST_W   = 6;
    localparam int UQ_DEPTH = 4;

    logic              clk;
    logic              rst_n;
    logic              flush_i, valid_i, ready_o;
    logic [31:0]       operand_1, operand_2, offset;
    logic [29:0]       pc;
    logic              auipc, lui, jal, jalr;
    logic [2:0]        bnch_cond;
    logic [ROB_W-1:0]  rob_id_i;
    logic [DEST_W-1:0] dest_i;
    logic [1:0]        bm_pred_i, btype_i;
    logic              btb_vld_i, btb_way_i;
    logic [29:0]       btb_target_i;
    logic [31:0]       result_o, excp_target_o, upd_target_o;
    logic              wb_valid_o, res_valid_o, excp_o;
    logic [DEST_W-1:0] wb_dest_o;
    logic [ROB_W-1:0]  rob_o;
    logic              upd_valid_o, upd_ready_i, upd_taken_o, upd_way_o, upd_mispred_o;
    logic [29:0]       upd_pc_o;
    logic [1:0]        upd_type_o, upd_bm_o;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]       perf_bnch_o, perf_misp_o;
    logic [31:0]       m_bnch, m_misp;
`endif

    branch_resolve_unit #(.ROB_W(ROB_W), .DEST_W(DEST_W), .UQ_DEPTH(UQ_DEPTH)) dut (
        .cpu_clock_i(clk), .cpu_reset_n_i(rst_n),
        .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .operand_1(operand_1), .operand_2(operand_2), .offset(offset), .pc(pc),
        .auipc(auipc), .lui(lui), .jal(jal), .jalr(jalr), .bnch_cond(bnch_cond),
        .rob_id_i(rob_id_i), .dest_i(dest_i),
        .bm_pred_i(bm_pred_i), .btype_i(btype_i), .btb_vld_i(btb_vld_i),
        .btb_target_i(btb_target_i), .btb_way_i(btb_way_i),
        .result_o(result_o), .wb_valid_o(wb_valid_o), .wb_dest_o(wb_dest_o),
        .res_valid_o(res_valid_o), .rob_o(rob_o),
        .excp_o(excp_o), .excp_target_o(excp_target_o),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_pc_o(upd_pc_o),
        .upd_target_o(upd_target_o), .upd_taken_o(upd_taken_o), .upd_type_o(upd_type_o),
        .upd_way_o(upd_way_o), .upd_bm_o(upd_bm_o), .upd_mispred_o(upd_mispred_o)
`ifdef BRU_PERF_CNT_EN
        , .perf_bnch_o(perf_bnch_o), .perf_misp_o(perf_misp_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [29:0] pc;
        logic [31:0] tgt;
        logic        tk;
        logic [1:0]  ty;
        logic        way;
        logic [1:0]  bm;
        logic        mp;
    } ent_t;

    ent_t              mq[$];
    logic              m_res_valid, m_wb_valid, m_excp;
    logic [31:0]       m_result, m_excp_tgt;
    logic [ROB_W-1:0]  m_rob;
    logic [DEST_W-1:0] m_dest;

    task automatic model_reset();
        mq.delete();
        m_res_valid = 0; m_wb_valid = 0; m_excp = 0;
        m_result = 0; m_excp_tgt = 0; m_rob = 0; m_dest = 0;
`ifdef BRU_PERF_CNT_EN
        m_bnch = 0; m_misp = 0;
`endif
    endtask

    // Spec rule: branch condition by funct3
    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a; sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Spec rule: correct next PC of the current input op
    function automatic logic [31:0] ref_npc();
        logic [31:0] base;
        base = pc * 4;
        if (jalr) return (operand_1 + offset) & 32'hFFFF_FFFE;
        if (jal)  return base + offset;
        if (!lui && !auipc && ref_cond(bnch_cond, operand_1, operand_2)) return base + offset;
        return base + 4;
    endfunction

    task automatic idle_inputs();
        flush_i = 0; valid_i = 0; lui = 0; auipc = 0; jal = 0; jalr = 0;
        operand_1 = 0; operand_2 = 0; offset = 0; pc = 0; bnch_cond = 0;
        rob_id_i = 0; dest_i = 0; bm_pred_i = 0; btype_i = 0; btb_vld_i = 0;
        btb_target_i = 0; btb_way_i = 0;
    endtask

    // One clock: check combinational queue view, advance model, check registered outputs.
    task automatic cycle();
        logic cf, br, tk, mp, acc, go;
        logic [31:0] npc, res;
        logic [1:0]  ty;
        ent_t        e;
        #1;
        check("ready", ready_o, mq.size() < UQ_DEPTH);
        check("upd_valid", upd_valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            check("head_pc", upd_pc_o, mq[0].pc);
            check("head_tgt", upd_target_o, mq[0].tgt);
            check("head_taken", upd_taken_o, mq[0].tk);
            check("head_type", upd_type_o, mq[0].ty);
            check("head_way", upd_way_o, mq[0].way);
            check("head_bm", upd_bm_o, mq[0].bm);
            check("head_mp", upd_mispred_o, mq[0].mp);
        end
        br  = !(lui || auipc || jal || jalr);
        cf  = br || jal || jalr;
        tk  = jal || jalr || (br && ref_cond(bnch_cond, operand_1, operand_2));
        npc = ref_npc();
        ty  = (jal || jalr) ? 2'b10 : 2'b00;
        mp  = cf && (!btb_vld_i || (btb_target_i * 4 != npc) || (btype_i != ty) ||
                     (br && tk != bm_pred_i[1]));
        res = lui ? offset : (auipc ? pc * 4 + offset : pc * 4 + 4);
        acc = valid_i && (mq.size() < UQ_DEPTH);
        go  = acc && !flush_i;
        if (mq.size() != 0 && upd_ready_i) void'(mq.pop_front());
        if (go && cf) begin
            e = '{pc: pc, tgt: npc, tk: tk, ty: ty, way: btb_way_i, bm: bm_pred_i, mp: mp};
            mq.push_back(e);
`ifdef BRU_PERF_CNT_EN
            m_bnch++;
            if (mp) m_misp++;
`endif
        end
        m_res_valid = go;
        m_wb_valid  = go && !br && (dest_i != 0);
        m_excp      = go && mp;
        if (go) begin
            m_result = res; m_rob = rob_id_i; m_dest = dest_i; m_excp_tgt = npc;
        end
        @(posedge clk);
        #1;
        check("res_valid", res_valid_o, m_res_valid);
        check("wb_valid", wb_valid_o, m_wb_valid);
        check("excp", excp_o, m_excp);
        check("result", result_o, m_result);
        check("rob", rob_o, m_rob);
        check("wb_dest", wb_dest_o, m_dest);
        if (m_excp) check("excp_tgt", excp_target_o, m_excp_tgt);
`ifdef BRU_PERF_CNT_EN
        check("perf_bnch", perf_bnch_o, m_bnch);
        check("perf_misp", perf_misp_o, m_misp);
`endif
    endtask

    task automatic random_op();
        int k;
        logic [31:0] npc;
        idle_inputs();
        k = $urandom_range(0, 5);
        lui = (k == 0); auipc = (k == 1); jal = (k == 2); jalr = (k == 3);
        case ($urandom_range(0, 5))
            0: bnch_cond = 3'd0; 1: bnch_cond = 3'd1; 2: bnch_cond = 3'd4;
            3: bnch_cond = 3'd5; 4: bnch_cond = 3'd6; default: bnch_cond = 3'd7;
        endcase
        operand_1 = $urandom();
        operand_2 = ($urandom_range(0, 3) == 0) ? operand_1 : $urandom();
        offset    = $urandom();
        pc        = 30'($urandom());
        rob_id_i  = ROB_W'($urandom());
        dest_i    = ($urandom_range(0, 4) == 0) ? '0 : DEST_W'($urandom());
        bm_pred_i = 2'($urandom());
        btb_way_i = 1'($urandom());
        btb_vld_i = ($urandom_range(0, 4) != 0);
        btype_i   = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : ((k == 2 || k == 3) ? 2'b10 : 2'b00);
        npc       = ref_npc();
        btb_target_i = ($urandom_range(0, 1) == 0) ? npc[31:2] : 30'($urandom());
        valid_i   = ($urandom_range(0, 4) != 0);
        flush_i   = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        idle_inputs();
        upd_ready_i = 0;
        model_reset();
        rst_n = 0;
        #3;
        check("rst_res_valid", res_valid_o, 0);
        check("rst_excp", excp_o, 0);
        check("rst_upd_valid", upd_valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_result", result_o, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // BEQ, correctly predicted taken
        upd_ready_i = 1;
        idle_inputs();
        valid_i = 1; bnch_cond = 3'b000; operand_1 = 5; operand_2 = 5;
        pc = 30'h100; offset = 32'h20; btb_vld_i = 1; btb_target_i = 30'h108;
        btype_i = 2'b00; bm_pred_i = 2'b10;
        cycle();
        check("beq_res_valid", res_valid_o, 1);
        check("beq_excp", excp_o, 0);
        check("beq_head_tgt", upd_target_o, 32'h420);
        check("beq_head_taken", upd_taken_o, 1);

        // BLT signed taken, predicted not taken
        idle_inputs();
        valid_i = 1; bnch_cond = 3'b100; operand_1 = 32'hFFFF_FFFF; operand_2 = 1;
        pc = 30'h200; offset = 32'h40; btb_vld_i = 1; btb_target_i = 30'h201; bm_pred_i = 2'b00;
        cycle();
        check("blt_excp", excp_o, 1);
        check("blt_tgt", excp_target_o, 32'h840);

        // BLTU same operands: not taken, prediction matches
        bnch_cond = 3'b110;
        cycle();
        check("bltu_excp", excp_o, 0);

        // jalr with link register
        idle_inputs();
        valid_i = 1; jalr = 1; operand_1 = 32'h1001; offset = 2; dest_i = 5; pc = 30'h300;
        cycle();
        check("jalr_tgt", excp_target_o, 32'h1002);
        check("jalr_wb", wb_valid_o, 1);
        check("jalr_result", result_o, 32'hC04);
        dest_i = 0;
        cycle();
        check("jalr_x0_wb", wb_valid_o, 0);

        // Drain, then fill the queue with back-pressure
        idle_inputs();
        repeat (3) cycle();
        upd_ready_i = 0;
        for (int i = 0; i < UQ_DEPTH; i++) begin
            idle_inputs();
            valid_i = 1; bnch_cond = 3'b001; operand_1 = i; pc = 30'(16 + i);
            cycle();
        end
        check("full_ready", ready_o, 0);
        pc = 30'h3FF;
        cycle();
        check("full_reject", res_valid_o, 0);
        idle_inputs();
        upd_ready_i = 1;
        cycle();
        upd_ready_i = 0;
        check("deq_ready", ready_o, 1);
        check("deq_head", upd_pc_o, 30'd17);

        // Flush blocks accept
        idle_inputs();
        valid_i = 1; flush_i = 1; jal = 1; pc = 30'h55;
        cycle();
        check("flush_res", res_valid_o, 0);
        check("flush_excp", excp_o, 0);
        idle_inputs();
        upd_ready_i = 1;
        cycle();
        upd_ready_i = 0;
        cycle();
        check("pre_rst_count", mq.size(), 2);

        // Asynchronous reset with two queued entries
        #2;
        rst_n = 0;
        #1;
        check("arst_upd_valid", upd_valid_o, 0);
        check("arst_ready", ready_o, 1);
        check("arst_res_valid", res_valid_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            random_op();
            upd_ready_i = ($urandom_range(0, 2) == 0);
            cycle();
        end
        idle_inputs();
        upd_ready_i = 1;
        repeat (UQ_DEPTH + 1) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
